// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between the 6502 core and a DMA requester.
// Zero-latency grant, DMA burst cap with one forced CPU slot, tagged read return.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int DMA_MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_rw,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rdy,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  input  logic                  dma_rw,
  output logic                  dma_gnt,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] MAX_BURST = 4'(DMA_MAX_BURST);

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DMA = 1'b1
  } state_t;

  // state_q is the owner of the previous cycle; with rd_pend it forms the read-return tag
  state_t          state_q;
  state_t          state_d;
  logic [3:0]      burst_cnt;
  logic            rd_pend;
  logic            cur_rw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_CPU;
    if (dma_req && (burst_cnt < MAX_BURST)) begin
      state_d = ST_DMA;
    end
  end

  // Outputs are forced low while reset is held so a grant drops asynchronously
  always_comb begin
    cpu_rdy   = 1'b0;
    dma_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cur_rw    = cpu_rw;
    if (state_d == ST_DMA) begin
      cur_rw = dma_rw;
    end
    if (reset) begin
      mem_en = 1'b1;
      if (state_d == ST_DMA) begin
        dma_gnt   = 1'b1;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = ~dma_rw;
      end else begin
        cpu_rdy   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = ~cpu_rw;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (state_d == ST_DMA) begin
        burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= '0;
      end
      rd_pend <= cur_rw;
      if (rd_pend && (state_q == ST_CPU)) begin
        cpu_rdata <= mem_rdata;
      end
      if (rd_pend && (state_q == ST_DMA)) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  assign dma_valid = rd_pend && (state_q == ST_DMA);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Inputs change just after the falling edge and are checked 1 time unit later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_en;
  logic [7:0]  mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (8),
    .DMA_MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rw   (cpu_rw),
    .cpu_rdata(cpu_rdata),
    .cpu_rdy  (cpu_rdy),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_rw   (dma_rw),
    .dma_gnt  (dma_gnt),
    .dma_rdata(dma_rdata),
    .dma_valid(dma_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_en   (mem_en),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    dma_req = 1'b1;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rdy: got %b want 0", cpu_rdy); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dma_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dma_valid: got %b want 0", dma_valid); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
    n_cmp++; if (dma_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_dma_rdata: got %h want 00", dma_rdata); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    dma_req = 1'b0;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    reset = 1'b1; dma_req = 1'b0; cpu_addr = 16'h1234; cpu_rw = 1'b1; mem_rdata = 8'h00;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_cpu_rdy: got %b want 1", cpu_rdy); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_dma_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (mem_addr !== 16'h1234) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 1234", mem_addr); end
    n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rd_mem_en: got %b want 1", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we: got %b want 0", mem_we); end
    @(negedge clk);
    mem_rdata = 8'hAD;
    #1;
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rd_early_rdata: got %h want 00", cpu_rdata); end
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_cpu_rdy2: got %b want 1", cpu_rdy); end
    @(negedge clk);
    #1;
    n_cmp++; if (cpu_rdata !== 8'hAD) begin n_fail++; $display("FAIL rd_cpu_rdata: got %h want ad", cpu_rdata); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_dma_gnt2: got %b want 0", dma_gnt); end
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    cpu_addr = 16'h0200; cpu_wdata = 8'h55; cpu_rw = 1'b0; mem_rdata = 8'hAD;
    #1;
    n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL wr_mem_en: got %b want 1", mem_en); end
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_wdata !== 8'h55) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want 55", mem_wdata); end
    n_cmp++; if (mem_addr !== 16'h0200) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 0200", mem_addr); end
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_cpu_rdy: got %b want 1", cpu_rdy); end
    @(negedge clk);
    cpu_addr = 16'h0201; cpu_rw = 1'b1; mem_rdata = 8'h66;
    #1;
    n_cmp++; if (cpu_rdata !== 8'hAD) begin n_fail++; $display("FAIL wr_rdata_a: got %h want ad", cpu_rdata); end
    @(negedge clk);
    cpu_rw = 1'b0; mem_rdata = 8'h00;
    #1;
    n_cmp++; if (cpu_rdata !== 8'hAD) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want ad", cpu_rdata); end
  endtask

  task automatic test_burst_cap();
    bit exp_gnt [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_drop [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit req_drop [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_addr;
    cpu_addr = 16'h0100; cpu_rw = 1'b1; dma_addr = 16'h8000; dma_rw = 1'b1; mem_rdata = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dma_req = 1'b1;
      #1;
      exp_addr = exp_gnt[i] ? 16'h8000 : 16'h0100;
      n_cmp++; if (dma_gnt !== exp_gnt[i]) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, dma_gnt, exp_gnt[i]); end
      n_cmp++; if (cpu_rdy !== !exp_gnt[i]) begin n_fail++; $display("FAIL burst_rdy[%0d]: got %b want %b", i, cpu_rdy, !exp_gnt[i]); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL burst_addr[%0d]: got %h want %h", i, mem_addr, exp_addr); end
    end
    // A request gap after two DMA cycles must clear the count: four more DMA cycles follow
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dma_req = req_drop[i];
      #1;
      n_cmp++; if (dma_gnt !== exp_drop[i]) begin n_fail++; $display("FAIL drop_gnt[%0d]: got %b want %b", i, dma_gnt, exp_drop[i]); end
    end
    @(negedge clk);
    dma_req = 1'b1;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL drop_forced_cpu: got %b want 1", cpu_rdy); end
  endtask

  task automatic test_alternating();
    @(negedge clk);
    dma_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 16'h0010; mem_rdata = 8'h00;
    @(negedge clk);
    cpu_rw = 1'b1; cpu_addr = 16'h00FF;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL alt_cpu_rdy: got %b want 1", cpu_rdy); end
    @(negedge clk);
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 16'h8000; mem_rdata = 8'h12;
    #1;
    n_cmp++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL alt_dma_gnt: got %b want 1", dma_gnt); end
    n_cmp++; if (mem_addr !== 16'h8000) begin n_fail++; $display("FAIL alt_dma_addr: got %h want 8000", mem_addr); end
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL alt_valid_cpu_slot: got %b want 0", dma_valid); end
    @(negedge clk);
    dma_req = 1'b0; mem_rdata = 8'h34;
    #1;
    n_cmp++; if (cpu_rdata !== 8'h12) begin n_fail++; $display("FAIL alt_cpu_rdata: got %h want 12", cpu_rdata); end
    n_cmp++; if (dma_valid !== 1'b1) begin n_fail++; $display("FAIL alt_dma_valid: got %b want 1", dma_valid); end
    n_cmp++; if (dma_rdata !== 8'h00) begin n_fail++; $display("FAIL alt_dma_rdata_early: got %h want 00", dma_rdata); end
    @(negedge clk);
    mem_rdata = 8'h12;
    #1;
    n_cmp++; if (dma_rdata !== 8'h34) begin n_fail++; $display("FAIL alt_dma_rdata: got %h want 34", dma_rdata); end
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL alt_valid_pulse: got %b want 0", dma_valid); end
    n_cmp++; if (cpu_rdata !== 8'h12) begin n_fail++; $display("FAIL alt_cpu_not_dma: got %h want 12", cpu_rdata); end
    @(negedge clk);
    cpu_rw = 1'b0;
    #1;
    n_cmp++; if (cpu_rdata !== 8'h12) begin n_fail++; $display("FAIL alt_cpu_final: got %h want 12", cpu_rdata); end
    n_cmp++; if (dma_rdata !== 8'h34) begin n_fail++; $display("FAIL alt_dma_final: got %h want 34", dma_rdata); end
  endtask

  task automatic test_dma_write_stall();
    @(negedge clk);
    cpu_addr = 16'h0300; cpu_rw = 1'b1;
    dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h4000; dma_wdata = 8'hAA;
    #1;
    n_cmp++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dw_dma_gnt: got %b want 1", dma_gnt); end
    n_cmp++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL dw_cpu_stall: got %b want 0", cpu_rdy); end
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL dw_mem_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 16'h4000) begin n_fail++; $display("FAIL dw_mem_addr: got %h want 4000", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'hAA) begin n_fail++; $display("FAIL dw_mem_wdata: got %h want aa", mem_wdata); end
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL dw_cpu_resume: got %b want 1", cpu_rdy); end
    n_cmp++; if (mem_addr !== 16'h0300) begin n_fail++; $display("FAIL dw_cpu_addr: got %h want 0300", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL dw_cpu_we: got %b want 0", mem_we); end
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL dw_no_valid: got %b want 0", dma_valid); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 16'h9000; mem_rdata = 8'h5A;
    #1;
    n_cmp++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmb_gnt1: got %b want 1", dma_gnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (dma_valid !== 1'b1) begin n_fail++; $display("FAIL rmb_valid: got %b want 1", dma_valid); end
    n_cmp++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmb_gnt2: got %b want 1", dma_gnt); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rmb_async_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rmb_async_en: got %b want 0", mem_en); end
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_async_valid: got %b want 0", dma_valid); end
    n_cmp++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL rmb_async_rdy: got %b want 0", cpu_rdy); end
    @(negedge clk);
    dma_req = 1'b0;
    @(negedge clk);
    reset = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0400;
    #1;
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rmb_first_cpu: got %b want 1", cpu_rdy); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rmb_first_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_post_valid: got %b want 0", dma_valid); end
    n_cmp++; if (dma_rdata !== 8'h00) begin n_fail++; $display("FAIL rmb_dma_rdata: got %h want 00", dma_rdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_post_valid2: got %b want 0", dma_valid); end
    n_cmp++; if (dma_rdata !== 8'h00) begin n_fail++; $display("FAIL rmb_dma_rdata2: got %h want 00", dma_rdata); end
  endtask

  initial begin
    reset = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_rw = 1'b1;
    dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_rw = 1'b1;
    mem_rdata = '0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_burst_cap();
    test_alternating();
    test_dma_write_stall();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one synchronous single-port memory (RAM/ROM) between the cpu6502 core and a DMA requester (loader/video fetch).
- Decides the bus owner every cycle and stalls the CPU through cpu_rdy when DMA owns the slot.
- Enforces a DMA burst cap so the CPU is never starved.
- Sits between cpu6502, the DMA engine and the memory. The top level resolves the CPU's inout data bus into cpu_wdata/cpu_rdata.

Parameters:
- ADDR_WIDTH, 16, address width of all ports.
- DATA_WIDTH, 8, data width of all ports.
- DMA_MAX_BURST, 4, maximum consecutive DMA-owned cycles before one CPU slot is forced (range 1..15).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_addr  input  ADDR_WIDTH  CPU address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_rw  input  1  1 = read, 0 = write (cpu6502 convention).
- cpu_rdata  output  DATA_WIDTH  registered read data to CPU.
- cpu_rdy  output  1  1 = CPU access performed this cycle; 0 = CPU must hold addr/rw/wdata.
- dma_req  input  1  DMA requests an access; held with address/data until granted.
- dma_addr  input  ADDR_WIDTH  DMA address.
- dma_wdata  input  DATA_WIDTH  DMA write data.
- dma_rw  input  1  1 = read, 0 = write.
- dma_gnt  output  1  DMA access performed this cycle.
- dma_rdata  output  DATA_WIDTH  registered DMA read data.
- dma_valid  output  1  one-cycle pulse: dma_rdata valid.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_we  output  1  memory write enable.
- mem_en  output  1  memory access enable.
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after an mem_en/!mem_we cycle.

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following:
  - cpu_rdy, dma_gnt, dma_valid, mem_en, mem_we = 0.
  - cpu_rdata, dma_rdata, mem_addr, mem_wdata = 0.
  - Burst counter = 0; owner = CPU.
  - Pending read tags cleared, so no dma_valid or cpu_rdata update after reset, even if a read was in flight.
- States:
  - CPU: default owner.
  - DMA: DMA owns the bus.
- Owner for the cycle is decided combinationally from registered state and inputs:
  - DMA when dma_req=1 and burst_cnt < DMA_MAX_BURST; otherwise CPU.
- When the CPU owns the cycle:
  - cpu_rdy=1 and dma_gnt=0.
  - mem_en=1, mem_addr=cpu_addr, mem_we=~cpu_rw, mem_wdata=cpu_wdata.
  - The CPU is treated as accessing every cycle it owns.
- When DMA owns the cycle:
  - dma_gnt=1 and cpu_rdy=0.
  - mem_addr=dma_addr, mem_we=~dma_rw, mem_wdata=dma_wdata.
- Outputs are combinational from the owner decision (zero-latency grant).
- cpu_rdy=0 stalls the CPU for reads and writes alike. The CPU holds its cycle and retries on the next rdy=1.
- burst_cnt behaviour:
  - Increments on each DMA-owned cycle.
  - Clears on any CPU-owned cycle.
  - When it reaches DMA_MAX_BURST with dma_req still 1, exactly one CPU cycle is forced, then DMA resumes.
- Read return:
  - A CPU read in cycle N loads cpu_rdata from mem_rdata at the end of cycle N+1.
  - A DMA read in cycle N loads dma_rdata at the end of cycle N+1 and pulses dma_valid=1 for cycle N+1.
  - Registers hold their value otherwise.
  - Back-to-back reads from alternating owners route correctly via a 1-bit owner/read tag per cycle.
- Writes: no read-data update, no dma_valid.
- Simultaneous events:
  - dma_req rising while a CPU read tag is pending: the CPU data is still captured.
  - Ownership change never loses in-flight read data.
- dma_req dropping mid-burst: the CPU owns the next cycle and burst_cnt clears.
- Reset asserted mid-burst: dma_gnt drops immediately (asynchronously).

Test Plan:
- Reset then release, no dma_req, CPU reads 0x1234 with mem returning 0xAD -> cpu_rdy=1 every cycle, mem_addr=0x1234, cpu_rdata=0xAD one cycle later, dma_gnt=0.
- CPU writes 0x55 to 0x0200 -> mem_en=1, mem_we=1, mem_wdata=0x55, mem_addr=0x0200 in the same cycle, cpu_rdata unchanged.
- dma_req held 10 cycles, DMA_MAX_BURST=4 -> dma_gnt pattern 1111 0 1111 0; cpu_rdy is the complement; burst_cnt never exceeds 4.
- Alternating CPU read 0x00FF (mem 0x12) and DMA read 0x8000 (mem 0x34) -> cpu_rdata=0x12 with no dma_valid in that cycle; dma_rdata=0x34 with dma_valid pulsing exactly one cycle; no cross-routing.
- DMA write 0xAA to 0x4000 during a CPU stall -> mem_we=1, mem_addr=0x4000, cpu_rdy=0; CPU access completes the next cycle with its held address.
- reset asserted low in the middle of a DMA read burst -> dma_gnt, mem_en and dma_valid go 0 immediately; no dma_valid after release; first cycle after release is CPU-owned.
